serial_word_alu: RTL



---
 rtl/serial_word_alu.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_word_alu.sv
// serial_word_alu: bit-serial ALU for WIDTH-bit operands, processed LSB-first.
// One result bit is produced per clock through a single-bit datapath with a
// carry register. A start/done handshake frames each operation. The parallel
// result and the zero flag are updated when the last bit has been computed.
module serial_word_alu #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             reclk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             aluout,
    output logic             regout,
    output logic             zero
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg, result_reg;
    logic [2:0]       op_reg;
    logic [CNTW-1:0]  cnt_reg;
    logic             carry_reg, aluout_reg, zacc_reg, zero_reg;

    logic             bit_val, carry_next, b_eff, is_arith;

    // State register
    always_ff @(posedge reclk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: DONE always lasts exactly one cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt_reg == LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        busy = (state_reg == S_RUN) || (state_reg == S_DONE);
        done = (state_reg == S_DONE);
    end

    // Single-bit function of the current operand bits and carry.
    // SUB reuses the adder with B inverted and carry preloaded to 1.
    always_comb begin
        is_arith   = (op_reg == OP_ADD) || (op_reg == OP_SUB);
        b_eff      = b_sr_reg[0] ^ (op_reg == OP_SUB);
        carry_next = carry_reg;
        case (op_reg)
            OP_ADD, OP_SUB: bit_val = a_sr_reg[0] ^ b_eff ^ carry_reg;
            OP_AND:         bit_val = a_sr_reg[0] & b_sr_reg[0];
            OP_OR:          bit_val = a_sr_reg[0] | b_sr_reg[0];
            OP_XOR:         bit_val = a_sr_reg[0] ^ b_sr_reg[0];
            OP_NOR:         bit_val = ~(a_sr_reg[0] | b_sr_reg[0]);
            OP_XNOR:        bit_val = ~(a_sr_reg[0] ^ b_sr_reg[0]);
            default:        bit_val = a_sr_reg[0];
        endcase
        if (is_arith) begin
            carry_next = (a_sr_reg[0] & b_eff) | (a_sr_reg[0] & carry_reg) | (b_eff & carry_reg);
        end
    end

    // Datapath: operand load on accept, one shift per RUN cycle, and a
    // parallel result/zero capture on the final bit only
    always_ff @(posedge reclk or posedge rst) begin
        if (rst) begin
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            aluout_reg <= 1'b0;
            zacc_reg   <= 1'b0;
            zero_reg   <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            if (start) begin
                a_sr_reg   <= a;
                b_sr_reg   <= b;
                op_reg     <= op;
                cnt_reg    <= '0;
                aluout_reg <= 1'b0;
                zacc_reg   <= 1'b1;
                carry_reg  <= (op == OP_SUB);
            end
        end else if (state_reg == S_RUN) begin
            a_sr_reg   <= a_sr_reg >> 1;
            b_sr_reg   <= b_sr_reg >> 1;
            res_sr_reg <= {bit_val, res_sr_reg[WIDTH-1:1]};
            aluout_reg <= bit_val;
            zacc_reg   <= zacc_reg & ~bit_val;
            carry_reg  <= carry_next;
            if (cnt_reg == LAST) begin
                result_reg <= {bit_val, res_sr_reg[WIDTH-1:1]};
                zero_reg   <= zacc_reg & ~bit_val;
            end else begin
                cnt_reg <= cnt_reg + CNTW'(1);
            end
        end
    end

    assign result = result_reg;
    assign aluout = aluout_reg;
    assign regout = carry_reg;
    assign zero   = zero_reg;

endmodule
